// File: rtl/mem_bist_sequencer.sv
// Sequences a write-then-read-compare BIST pass across up to four memories on a shared bus.
// Define MEM_BIST_FIRST_ERR_ADDR_EN to capture each memory's first failing read address.
module mem_bist_sequencer #(
    parameter int MEM1_DEPTH = 32,
    parameter int MEM2_DEPTH = 32,
    parameter int MEM3_DEPTH = 32,
    parameter int MEM4_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [3:0]  enMask_i,
    input  logic [7:0]  seed_i,
    input  logic [1:0]  patType_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  memSel_o,
    output logic [7:0]  addr_o,
    output logic [7:0]  wrData_o,
    output logic        wrEn_o,
    output logic        rdEn_o,
    input  logic [7:0]  rdData_i,
    output logic [31:0] errCnt_o,
    output logic [3:0]  fail_o,
    output logic [31:0] firstErrAddr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] LAST1 = 8'(MEM1_DEPTH - 1);
    localparam logic [7:0] LAST2 = 8'(MEM2_DEPTH - 1);
    localparam logic [7:0] LAST3 = 8'(MEM3_DEPTH - 1);
    localparam logic [7:0] LAST4 = 8'(MEM4_DEPTH - 1);

    function automatic logic [7:0] last_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return LAST1;
            2'd1:    return LAST2;
            2'd2:    return LAST3;
            default: return LAST4;
        endcase
    endfunction

    function automatic logic [7:0] next_pattern(input logic [7:0] p, input logic [1:0] t);
        case (t)
            2'b00:   return ~p;
            2'b01:   return p + 8'd1;
            2'b10:   return p - 8'd1;
            default: return 8'hFF;
        endcase
    endfunction

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] find_enabled(input logic [3:0] mask);
        logic [2:0] hit;
        hit = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) hit = {1'b1, 2'(i)};
        end
        return hit;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  pat_q, pat_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  seed_q, seed_d;
    logic [1:0]  ptype_q, ptype_d;
    logic        start_acc;

    logic        busy_q, done_q, wr_en_q, rd_en_q;
    logic        cmp_valid_q;
    logic [7:0]  exp_q;
    logic        mismatch;
    logic [7:0]  err_q [4];

    logic [2:0]  first_hit, next_hit;
    logic [3:0]  above_sel;

    // Bits strictly above the one-hot selection, so DRAIN only looks forward.
    assign above_sel = ~(sel_q | (sel_q - 4'd1));
    assign first_hit = find_enabled(enMask_i);
    assign next_hit  = find_enabled(mask_q & above_sel);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        mask_d    = mask_q;
        seed_d    = seed_q;
        ptype_d   = ptype_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    mask_d    = enMask_i;
                    seed_d    = seed_i;
                    ptype_d   = patType_i;
                    if (first_hit[2]) begin
                        state_d = S_WRITE;
                        idx_d   = first_hit[1:0];
                        sel_d   = 4'd1 << first_hit[1:0];
                        addr_d  = 8'd0;
                        pat_d   = seed_i;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == last_addr(idx_q)) begin
                    state_d = S_READ;
                    addr_d  = 8'd0;
                    pat_d   = seed_q;
                end else begin
                    addr_d = addr_q + 8'd1;
                    pat_d  = next_pattern(pat_q, ptype_q);
                end
            end
            S_READ: begin
                if (addr_q == last_addr(idx_q)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 8'd1;
                    pat_d  = next_pattern(pat_q, ptype_q);
                end
            end
            S_DRAIN: begin
                if (next_hit[2]) begin
                    state_d = S_WRITE;
                    idx_d   = next_hit[1:0];
                    sel_d   = 4'd1 << next_hit[1:0];
                    addr_d  = 8'd0;
                    pat_d   = seed_q;
                end else begin
                    state_d = S_DONE;
                    sel_d   = 4'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 4'd0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with addr/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            sel_q       <= 4'd0;
            addr_q      <= 8'd0;
            pat_q       <= 8'hAA;
            mask_q      <= 4'd0;
            seed_q      <= 8'd0;
            ptype_q     <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            exp_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            mask_q      <= mask_d;
            seed_q      <= seed_d;
            ptype_q     <= ptype_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            wr_en_q     <= (state_d == S_WRITE);
            rd_en_q     <= (state_d == S_READ);
            cmp_valid_q <= (state_q == S_READ);
            exp_q       <= pat_q;
        end
    end

    // Read data returns one cycle after the strobe, so compare against the delayed expectation.
    assign mismatch = cmp_valid_q && (rdData_i != exp_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) err_q[i] <= 8'd0;
        end else if (start_acc) begin
            for (int i = 0; i < 4; i++) err_q[i] <= 8'd0;
        end else if (mismatch && (err_q[idx_q] != 8'hFF)) begin
            err_q[idx_q] <= err_q[idx_q] + 8'd1;
        end
    end

`ifdef MEM_BIST_FIRST_ERR_ADDR_EN
    logic [7:0] cmp_addr_q;
    logic [7:0] first_q [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_addr_q <= 8'd0;
            for (int i = 0; i < 4; i++) first_q[i] <= 8'd0;
        end else begin
            cmp_addr_q <= addr_q;
            if (start_acc) begin
                for (int i = 0; i < 4; i++) first_q[i] <= 8'd0;
            end else if (mismatch && (err_q[idx_q] == 8'd0)) begin
                first_q[idx_q] <= cmp_addr_q;
            end
        end
    end

    assign firstErrAddr_o = {first_q[3], first_q[2], first_q[1], first_q[0]};
`else
    assign firstErrAddr_o = 32'd0;
`endif

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign memSel_o = sel_q;
    assign addr_o   = addr_q;
    assign wrData_o = pat_q;
    assign wrEn_o   = wr_en_q;
    assign rdEn_o   = rd_en_q;
    assign errCnt_o = {err_q[3], err_q[2], err_q[1], err_q[0]};
    assign fail_o   = {|err_q[3], |err_q[2], |err_q[1], |err_q[0]};

endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Self-checking bench for mem_bist_sequencer: a memory model with fault injection on the
// read path, and a per-cycle bus trace predicted from the pattern rules.
module tb_mem_bist_sequencer;

    localparam int D1 = 4;
    localparam int D2 = 32;
    localparam int D3 = 1;
    localparam int D4 = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  enMask_i;
    logic [7:0]  seed_i;
    logic [1:0]  patType_i;
    logic        busy_o, done_o, wrEn_o, rdEn_o;
    logic [3:0]  memSel_o, fail_o;
    logic [7:0]  addr_o, wrData_o, rdData_i;
    logic [31:0] errCnt_o, firstErrAddr_o;

    int n_cmp = 0;
    int n_err = 0;
    int fault_mode = 0;
    logic [7:0] mem [4][256];

    always #5 clk = ~clk;

    mem_bist_sequencer #(
        .MEM1_DEPTH(D1), .MEM2_DEPTH(D2), .MEM3_DEPTH(D3), .MEM4_DEPTH(D4)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .enMask_i(enMask_i),
        .seed_i(seed_i), .patType_i(patType_i), .busy_o(busy_o), .done_o(done_o),
        .memSel_o(memSel_o), .addr_o(addr_o), .wrData_o(wrData_o), .wrEn_o(wrEn_o),
        .rdEn_o(rdEn_o), .rdData_i(rdData_i), .errCnt_o(errCnt_o), .fail_o(fail_o),
        .firstErrAddr_o(firstErrAddr_o)
    );

    function automatic int depth_of(input int m);
        case (m)
            0:       return D1;
            1:       return D2;
            2:       return D3;
            default: return D4;
        endcase
    endfunction

    // Fault 1: mem2 addr2 bit0 flipped; 2: mem4 stuck at 00; 3: mem1 addr0 bit0 flipped.
    function automatic logic [7:0] apply_fault(input int m, input int a, input logic [7:0] v);
        case (fault_mode)
            1:       return (m == 1 && a == 2) ? (v ^ 8'h01) : v;
            2:       return (m == 3) ? 8'h00 : v;
            3:       return (m == 0 && a == 0) ? (v ^ 8'h01) : v;
            default: return v;
        endcase
    endfunction

    // Word a of the sequence, straight from the pattern rule.
    function automatic logic [7:0] pat_word(input logic [7:0] seed, input logic [1:0] t, input int a);
        case (t)
            2'b00:   return (a % 2 == 0) ? seed : ~seed;
            2'b01:   return seed + 8'(a);
            2'b10:   return seed - 8'(a);
            default: return (a == 0) ? seed : 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrEn_o && memSel_o == (4'd1 << i)) mem[i][addr_o] <= wrData_o;
            if (rdEn_o && memSel_o == (4'd1 << i)) rdData_i <= apply_fault(i, int'(addr_o), mem[i][addr_o]);
        end
    end

    function automatic logic [23:0] ent(input logic b, input logic d, input logic [3:0] s,
                                        input logic we, input logic re, input logic [7:0] a,
                                        input logic [7:0] wd);
        return {b, d, s, we, re, a, wd};
    endfunction

    function automatic logic [23:0] observe();
        return {busy_o, done_o, memSel_o, wrEn_o, rdEn_o,
                (wrEn_o | rdEn_o) ? addr_o : 8'h00, wrEn_o ? wrData_o : 8'h00};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 64'({busy_o, done_o, memSel_o, wrEn_o, rdEn_o, addr_o, wrData_o}),
              64'({1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 8'hAA}));
        check({tag, "_err"}, 64'({errCnt_o, fail_o}), 64'd0);
        check({tag, "_first"}, 64'(firstErrAddr_o), 64'd0);
    endtask

    task automatic run(input logic [3:0] mask, input logic [7:0] seed, input logic [1:0] ptype,
                       input int fmode, input bit mid_start, input string tag);
        logic [23:0] exp_q[$];
        logic [7:0]  exp_err [4];
        logic [7:0]  exp_first [4];
        logic [31:0] exp_first_bus;
        logic [3:0]  sel;
        logic [7:0]  w;
        int cyc;
        fault_mode = fmode;
        for (int m = 0; m < 4; m++) begin
            exp_err[m] = 8'd0;
            exp_first[m] = 8'd0;
            if (mask[m]) begin
                sel = 4'd1 << m;
                for (int a = 0; a < depth_of(m); a++)
                    exp_q.push_back(ent(1'b1, 1'b0, sel, 1'b1, 1'b0, 8'(a), pat_word(seed, ptype, a)));
                for (int a = 0; a < depth_of(m); a++) begin
                    exp_q.push_back(ent(1'b1, 1'b0, sel, 1'b0, 1'b1, 8'(a), 8'h00));
                    w = pat_word(seed, ptype, a);
                    if (apply_fault(m, a, w) != w) begin
                        if (exp_err[m] == 8'd0) exp_first[m] = 8'(a);
                        if (exp_err[m] != 8'hFF) exp_err[m] = exp_err[m] + 8'd1;
                    end
                end
                exp_q.push_back(ent(1'b1, 1'b0, sel, 1'b0, 1'b0, 8'h00, 8'h00));
            end
        end
        exp_q.push_back(ent(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00));
        exp_q.push_back(ent(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00));

        @(negedge clk);
        start_i = 1'b1; enMask_i = mask; seed_i = seed; patType_i = ptype;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            start_i   = (mid_start && cyc == 20);
            enMask_i  = 4'($urandom);
            seed_i    = 8'($urandom);
            patType_i = 2'($urandom);
            check($sformatf("%s_trace_c%0d", tag, cyc), 64'(observe()), 64'(exp_q.pop_front()));
        end
`ifdef MEM_BIST_FIRST_ERR_ADDR_EN
        exp_first_bus = {exp_first[3], exp_first[2], exp_first[1], exp_first[0]};
`else
        exp_first_bus = 32'd0;
`endif
        repeat (2) @(negedge clk);
        check({tag, "_errcnt"}, 64'(errCnt_o), 64'({exp_err[3], exp_err[2], exp_err[1], exp_err[0]}));
        check({tag, "_fail"}, 64'(fail_o), 64'({|exp_err[3], |exp_err[2], |exp_err[1], |exp_err[0]}));
        check({tag, "_first"}, 64'(firstErrAddr_o), 64'(exp_first_bus));
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; enMask_i = 4'd0; seed_i = 8'd0; patType_i = 2'd0;
        #2;
        check_reset_vals("reset_init");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(4'b0001, 8'hAA, 2'b00, 0, 1'b0, "invert");
        run(4'b0010, 8'h10, 2'b01, 1, 1'b0, "fault");
        run(4'b1010, 8'($urandom), 2'($urandom), 0, 1'b1, "order");
        run(4'b0000, 8'($urandom), 2'($urandom), 0, 1'b0, "empty");
        run(4'b1000, 8'hFF, 2'b11, 2, 1'b0, "saturate");
        run(4'b0100, 8'($urandom), 2'($urandom), 0, 1'b0, "depth1");
        for (int r = 0; r < 6; r++)
            run(4'($urandom_range(0, 15)), 8'($urandom), 2'($urandom), $urandom_range(0, 3), 1'b0,
                $sformatf("rand%0d", r));

        // Abort a run in READ of memory 1 once a mismatch has been counted.
        fault_mode = 3;
        @(negedge clk);
        start_i = 1'b1; enMask_i = 4'b0001; seed_i = 8'($urandom); patType_i = 2'($urandom);
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun_pre_err", 64'(errCnt_o), 64'd1);
        check("midrun_pre_rd", 64'({rdEn_o, memSel_o}), 64'({1'b1, 4'b0001}));
        reset = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        run(4'b0001, 8'($urandom), 2'($urandom), 0, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bist_sequencer.md
# mem_bist_sequencer

Controller that sequences the parallel-interface memory BIST across up to four memories. It runs a write-then-read-compare pass on each enabled memory in turn, and drives one shared address/data/write-enable bus qualified by a one-hot memory select. It also accumulates per-memory error counts. It sits between the core's BIST configuration register and the memory datapath ports.

## Interface
- MEM1_DEPTH, 32, number of words in memory 1 (1..256)
- MEM2_DEPTH, 32, words in memory 2 (1..256)
- MEM3_DEPTH, 32, words in memory 3 (1..256)
- MEM4_DEPTH, 32, words in memory 4 (1..256)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start_i  in  1  start request; sampled only in IDLE
- enMask_i  in  4  memory enable mask, bit i = memory i+1
- seed_i  in  8  first pattern word
- patType_i  in  2  pattern rule: 00 invert, 01 +1, 10 −1, 11 constant 8'hFF
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- memSel_o  out  4  one-hot memory under test; 0 when idle
- addr_o  out  8  word address
- wrData_o  out  8  write data
- wrEn_o  out  1  write strobe
- rdEn_o  out  1  read strobe
- rdData_i  in  8  read data, valid the cycle after rdEn_o
- errCnt_o  out  32  four 8-bit saturating error counts; [7:0] = memory 1
- fail_o  out  4  bit i high when errCnt for memory i+1 is nonzero
- firstErrAddr_o  out  32  four 8-bit first-failing addresses (see Configuration)

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
- **Start:** an edge in IDLE with start_i=1 latches enMask_i, seed_i and patType_i, and clears all errCnt and firstErrAddr.
  - Next state is WRITE for the lowest-index enabled memory.
  - If the mask is 0, next state is DONE.
- **start_i outside IDLE:** ignored.
- **WRITE:** one write per cycle at addr 0..N−1, where N is the selected memory's depth.
  - wrData at addr 0 = seed.
  - Each following word = nextPattern(previous word, patType).
  - After addr N−1 the FSM goes to READ with addr reset to 0 and the pattern generator reloaded with seed.
- **READ:** one read per cycle at addr 0..N−1, regenerating the same pattern sequence as the expected value.
  - The expected value is delayed one cycle and compared with rdData_i.
  - After addr N−1 the FSM goes to DRAIN.
- **DRAIN:** one cycle that performs the final compare.
  - Then WRITE for the next higher-index enabled memory, or DONE if none remains.
- **DONE:** done_o=1 for one cycle, then IDLE.
- **Mismatch:** increments the selected memory's errCnt.
  - Saturates at 8'hFF; no wrap.
  - fail_o is combinational from errCnt.
- **Hold:** errCnt, fail_o and firstErrAddr hold their values through IDLE until the next accepted start.
- **Reset mid-run:** the FSM returns to IDLE immediately. Any in-flight compare is discarded and all outputs take their reset values.

## Timing
- **Reset values:** state IDLE; busy_o, done_o, wrEn_o and rdEn_o all 0; memSel_o, addr_o, errCnt_o, firstErrAddr_o and fail_o all 0; wrData_o 8'hAA.
- **Registered outputs:** every output except fail_o is registered.
- **After start:** the first wrEn_o appears in the cycle following the start edge.
- **Per memory:** exactly 2N+1 cycles (N WRITE + N READ + 1 DRAIN).
- **Between memories:** no gap; the next memory's WRITE directly follows DRAIN.
- **Total latency:** from start edge to done_o = Σ(2N_i+1) over enabled memories, plus 1 cycle.
- **Strobes:** wrEn_o and rdEn_o are never both high; memSel_o is stable during each memory's whole run.
- **Depth 1:** a memory with depth 1 produces 1 write, 1 read and DRAIN.

## Configuration
- **Macro:** `MEM_BIST_FIRST_ERR_ADDR_EN`.
- **When defined:** each memory's first mismatch records the read address in its firstErrAddr_o byte. The byte holds until the next accepted start; later mismatches do not overwrite it.
- **When undefined:** firstErrAddr_o is constant 0 and no capture registers are built. The rest of the behaviour is identical.

## Test plan
- **Single memory, invert:** MEM1_DEPTH=4, mask 0001, seed AA, pat 00.
  - Required: writes AA,55,AA,55 to addr 0..3, then 4 reads.
  - Required: done_o 10 cycles after the start edge, errCnt_o=0, fail_o=0.
- **Injected fault:** mask 0010, pat 01, seed 10, with a bench model that flips bit 0 at memory 2 addr 2.
  - Required: errCnt_o[15:8]=1, fail_o=0010.
  - Required: firstErrAddr_o[15:8]=2 when the macro is defined, 0 when it is not.
- **Ordering:** mask 1010 with depths 32.
  - Required: memSel_o goes 0010 then 1000 with no gap.
  - Required: done_o at cycle 131; a start_i pulse mid-run has no effect.
- **Empty mask:** mask 0000.
  - Required: done_o one cycle after the start edge, memSel_o stays 0.
- **Saturation:** MEM4_DEPTH=256, mask 1000, memory stuck at 00, seed FF, pat 11.
  - Required: errCnt_o[31:24]=FF with no wrap.
- **Reset mid-run:** reset asserted during READ of memory 1.
  - Required: all outputs at their reset values in the same cycle; a new start runs cleanly with errCnt starting from 0.
